// File: rtl/bcd4_counter_pkg.sv
// Shared BCD constants, digit type and a load-sanitising helper for the counter.
// The constant values are the same ones the x7seg display stage uses.
package bcd4_counter_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam int         DIGITS   = 4;
    localparam int         DIG_W    = 4;

    typedef logic [DIG_W-1:0] bcd_t;

    // A nibble that is not a decimal digit is loaded as zero.
    function automatic bcd_t bcd_sanitize(input bcd_t n);
        return (n > BCD_MAX) ? BCD_ZERO : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with parallel load and carry/borrow out. Decades are chained
// by feeding co into the next decade's en. Down counting exists only with BCD_DOWN_EN.
module bcd_digit
    import bcd4_counter_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic up,
    input  logic ld,
    input  bcd_t d,
    output bcd_t q,
    output logic co
);

    bcd_t q_q;
    bcd_t q_d;

`ifdef BCD_DOWN_EN
    assign co = en & (up ? (q_q == BCD_MAX) : (q_q == BCD_ZERO));

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (en) begin
            if (up) begin
                q_d = (q_q == BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end
`else
    logic unused_up;
    assign unused_up = up;

    assign co = en & (q_q == BCD_MAX);

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bcd4_counter.sv
// 4-digit BCD counter stepped by a clk prescaler, with parallel load and a wrap pulse.
// Define BCD_DOWN_EN to let up_dn select down counting; otherwise up_dn is ignored.
module bcd4_counter
    import bcd4_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        up_dn,
    output logic [15:0] x,
    output logic        tick,
    output logic        cout
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     psc_q;
    logic [PW-1:0]     psc_d;
    logic              cout_q;
    logic              dir_up;
    logic [DIGITS:0]   en_chain;
    logic [15:0]       din_clean;
    logic [15:0]       x_digits;

`ifdef BCD_DOWN_EN
    assign dir_up = up_dn;
`else
    logic unused_up_dn;
    assign unused_up_dn = up_dn;
    assign dir_up       = 1'b1;
`endif

    assign tick = run & (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q;
        if (load) begin
            psc_d = '0;
        end else if (run) begin
            psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PW'(1);
        end
    end

    // A load in the tick cycle swallows that tick, so the chain is never enabled.
    assign en_chain[0] = tick & ~load;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign din_clean[gi*DIG_W +: DIG_W] = bcd_sanitize(din[gi*DIG_W +: DIG_W]);

            bcd_digit u_digit (
                .clk (clk),
                .clr (clr),
                .en  (en_chain[gi]),
                .up  (dir_up),
                .ld  (load),
                .d   (din_clean[gi*DIG_W +: DIG_W]),
                .q   (x_digits[gi*DIG_W +: DIG_W]),
                .co  (en_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            psc_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            cout_q <= en_chain[DIGITS];
        end
    end

    assign x    = x_digits;
    assign cout = cout_q;

endmodule

// File: tb/tb_bcd4_counter.sv
// Self-checking bench for bcd4_counter (TICK_DIV=4) against a decimal-integer model.
// Down-count scenario is exercised only when BCD_DOWN_EN is defined.
module tb_bcd4_counter;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic        load;
    logic [15:0] din;
    logic        up_dn;
    logic [15:0] x;
    logic        tick;
    logic        cout;

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain integer 0..9999, prescaler phase as an integer.
    int m_val   = 0;
    int m_phase = 0;
    bit m_cout  = 1'b0;

    bcd4_counter #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .clr   (clr),
        .run   (run),
        .load  (load),
        .din   (din),
        .up_dn (up_dn),
        .x     (x),
        .tick  (tick),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = 16'((v / 1000) % 10) << 12;
        r = r | (16'((v / 100) % 10) << 8);
        r = r | (16'((v / 10) % 10) << 4);
        r = r | 16'(v % 10);
        return r;
    endfunction

    function automatic int dec_of(input logic [15:0] d);
        int v;
        int nib;
        v = 0;
        for (int k = 3; k >= 0; k--) begin
            nib = int'((d >> (4 * k)) & 16'h000F);
            if (nib > 9) nib = 0;
            v = v * 10 + nib;
        end
        return v;
    endfunction

    function automatic bit exp_tick();
        return run && !clr && (m_phase == TD - 1);
    endfunction

    function automatic bit model_up();
`ifdef BCD_DOWN_EN
        return up_dn;
`else
        return 1'b1;
`endif
    endfunction

    // Advance one clock edge and update the model from the inputs held across it.
    task automatic step();
        bit t;
        bit u;
        t = exp_tick();
        u = model_up();
        @(posedge clk);
        if (clr) begin
            m_val = 0; m_phase = 0; m_cout = 1'b0;
        end else if (load) begin
            m_val = dec_of(din); m_phase = 0; m_cout = 1'b0;
        end else begin
            m_cout = 1'b0;
            if (run) begin
                if (t) begin
                    if (u) begin
                        m_val = (m_val + 1) % 10000;
                        m_cout = (m_val == 0);
                    end else begin
                        m_val = (m_val + 9999) % 10000;
                        m_cout = (m_val == 9999);
                    end
                end
                m_phase = (m_phase + 1) % TD;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; run = 1'b1; load = 1'b0; din = 16'h0000; up_dn = 1'b1;
        #1;
        checks++;
        if (x !== 16'h0000 || cout !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: x=%h cout=%b tick=%b, want x=0000 cout=0 tick=0", x, cout, tick);
        end
        repeat (3) step();
        clr = 1'b0;
        m_val = 0; m_phase = 0; m_cout = 1'b0;
        for (int i = 0; i < TD; i++) begin
            #1;
            checks++;
            if (tick !== exp_tick()) begin
                errors++;
                $display("FAIL reset_tick[%0d]: tick=%b want %b", i, tick, exp_tick());
            end
            step();
        end
        checks++;
        if (x !== 16'h0001 || cout !== 1'b0) begin
            errors++;
            $display("FAIL first_step: x=%h cout=%b, want x=0001 cout=0", x, cout);
        end
        $display("test_reset: x=%h after first tick", x);
    endtask

    task automatic test_carry();
        bit seen_cout;
        seen_cout = 1'b0;
        load = 1'b1; din = 16'h0009; run = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < TD; i++) begin
            step();
            if (cout === 1'b1) seen_cout = 1'b1;
        end
        checks++;
        if (x !== 16'h0010 || seen_cout) begin
            errors++;
            $display("FAIL digit_carry: x=%h cout_seen=%b, want x=0010 cout_seen=0", x, seen_cout);
        end
        $display("test_carry: x=%h", x);
    endtask

    task automatic test_wrap();
        load = 1'b1; din = 16'h9999; run = 1'b1;
        step();
        load = 1'b0;
        repeat (TD) step();
        checks++;
        if (x !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up: x=%h cout=%b, want x=0000 cout=1", x, cout);
        end
        step();
        checks++;
        if (cout !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse_width: cout=%b want 0", cout);
        end
        $display("test_wrap: x=%h", x);
    endtask

    task automatic test_load_priority();
        int n;
        n = 0;
        run = 1'b1; load = 1'b0;
        while (!exp_tick() && n < 2 * TD) begin
            step();
            n++;
        end
        #1;
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL prio_tick_cycle: tick=%b want 1 (waited %0d)", tick, n);
        end
        load = 1'b1; din = 16'h1234;
        step();
        load = 1'b0;
        checks++;
        if (x !== 16'h1234) begin
            errors++;
            $display("FAIL load_priority: x=%h want 1234", x);
        end
        repeat (TD - 1) step();
        checks++;
        if (x !== 16'h1234) begin
            errors++;
            $display("FAIL load_hold: x=%h want 1234", x);
        end
        step();
        checks++;
        if (x !== 16'h1235) begin
            errors++;
            $display("FAIL load_next_step: x=%h want 1235", x);
        end
        $display("test_load_priority: x=%h", x);
    endtask

    task automatic test_invalid_freeze();
        logic [15:0] held;
        load = 1'b1; din = 16'hA5F3; run = 1'b0;
        step();
        load = 1'b0;
        checks++;
        if (x !== 16'h0503) begin
            errors++;
            $display("FAIL invalid_bcd: x=%h want 0503", x);
        end
        held = 16'h0503;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (tick !== 1'b0 || x !== held) begin
                errors++;
                $display("FAIL freeze[%0d]: x=%h tick=%b, want x=%h tick=0", i, x, tick, held);
            end
            step();
        end
        $display("test_invalid_freeze: x=%h", x);
    endtask

    task automatic test_down();
`ifdef BCD_DOWN_EN
        load = 1'b1; din = 16'h0000; run = 1'b1; up_dn = 1'b0;
        step();
        load = 1'b0;
        repeat (TD) step();
        checks++;
        if (x !== 16'h9999 || cout !== 1'b1) begin
            errors++;
            $display("FAIL borrow_down: x=%h cout=%b, want x=9999 cout=1", x, cout);
        end
        up_dn = 1'b1;
        $display("test_down: x=%h", x);
`else
        $display("test_down: down counting not built");
`endif
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            run  = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 19) == 0);
            r    = int'($urandom_range(0, 2));
            din  = (r == 0) ? 16'($urandom) : to_bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
            #1;
            checks++;
            if (tick !== exp_tick()) begin
                errors++;
                $display("FAIL rand_tick[%0d]: tick=%b want %b", i, tick, exp_tick());
            end
            step();
            checks++;
            if (x !== to_bcd(m_val) || cout !== m_cout) begin
                errors++;
                $display("FAIL rand_state[%0d]: x=%h cout=%b, want x=%h cout=%b", i, x, cout, to_bcd(m_val), m_cout);
            end
        end
        load = 1'b0; up_dn = 1'b1;
        $display("test_random: final x=%h", x);
    endtask

    task automatic test_async_clear();
        load = 1'b1; din = 16'h4321; run = 1'b1;
        step();
        load = 1'b0;
        step();
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if (x !== 16'h0000 || cout !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: x=%h cout=%b tick=%b, want 0000 0 0", x, cout, tick);
        end
        step();
        clr = 1'b0;
        m_val = 0; m_phase = 0; m_cout = 1'b0;
        repeat (TD) step();
        checks++;
        if (x !== 16'h0001) begin
            errors++;
            $display("FAIL after_clear: x=%h want 0001", x);
        end
        $display("test_async_clear: x=%h", x);
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_load_priority();
        test_invalid_freeze();
        test_down();
        test_random();
        test_async_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
